// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift datapath: deserializer FSM states
// and the default word width used on both sides of the serial link.
package shift_pkg;

    // Deserializer frame-tracking states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } deser_state_t;

    // Default parallel word width and its counter sizing exponent
    localparam int DEFAULT_TO     = 32;
    localparam int DEFAULT_LOG2TO = 5;

endpackage

// File: rtl/deser_out_buf.sv
// Single-entry output holding register with valid/ready handshake.
// A completed word is accepted when the slot is empty or is being drained in
// the same cycle; otherwise the new word is dropped and an overflow pulse is
// raised for one cycle while the held word stays untouched.
module deser_out_buf #(
    parameter int TO = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          word_valid,
    input  logic [TO-1:0] word_data,
    input  logic          ready_i,
    output logic [TO-1:0] data_o,
    output logic          valid_o,
    output logic          overflow_o
);

    logic [TO-1:0] data_reg;
    logic          valid_reg;
    logic          overflow_reg;

    // Load, hold or drain the output word; flag a dropped word next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= 1'b0;
            if (word_valid) begin
                if (!valid_reg || ready_i) begin
                    data_reg  <= word_data;
                    valid_reg <= 1'b1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (valid_reg && ready_i) begin
                // data_reg keeps its last value after the transfer
                valid_reg <= 1'b0;
            end
        end
    end

    assign data_o     = data_reg;
    assign valid_o    = valid_reg;
    assign overflow_o = overflow_reg;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter. Bits arrive MSB first while valid_i is high;
// a frame that reaches TO bits produces one word, extra trailing bits are
// swallowed in DRAIN, and a frame that ends early raises frame_err_o.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int TO     = DEFAULT_TO,
    parameter int LOG2TO = DEFAULT_LOG2TO
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_i,
    input  logic          valid_i,
    input  logic          ready_i,
    output logic [TO-1:0] data_o,
    output logic          valid_o,
    output logic          overflow_o,
    output logic          frame_err_o
);

    localparam logic [LOG2TO:0] COUNT_ONE  = (LOG2TO+1)'(1);
    localparam logic [LOG2TO:0] LAST_COUNT = (LOG2TO+1)'(TO - 1);

    deser_state_t    state_reg;
    logic [TO-1:0]   sr_reg;
    logic [LOG2TO:0] count_reg;
    logic            frame_err_reg;

    logic            word_done;
    logic [TO-1:0]   word_next;

    // The word completes on the edge that samples the TO-th bit, so the
    // output buffer is fed combinationally to give one cycle of latency.
    assign word_next = {sr_reg[TO-2:0], data_i};
    assign word_done = (state_reg == COLLECT) && valid_i && (count_reg == LAST_COUNT);

    // Frame FSM, bit counter and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            count_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        sr_reg    <= {{(TO-1){1'b0}}, data_i};
                        count_reg <= COUNT_ONE;
                        state_reg <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (valid_i) begin
                        sr_reg    <= word_next;
                        count_reg <= count_reg + COUNT_ONE;
                        if (count_reg == LAST_COUNT) begin
                            state_reg <= DRAIN;
                        end
                    end else begin
                        // Frame ended short: drop the partial word
                        sr_reg        <= '0;
                        count_reg     <= '0;
                        frame_err_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!valid_i) begin
                        sr_reg    <= '0;
                        count_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    sr_reg    <= '0;
                    count_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    deser_out_buf #(
        .TO(TO)
    ) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .word_valid (word_done),
        .word_data  (word_next),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    assign frame_err_o = frame_err_reg;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer with an 8-bit and a 32-bit
// instance. Expected words are queued as frames are driven and popped when
// the DUT presents them.
module tb_shift_deserializer;

    logic        clk = 1'b0;
    logic        reset;

    logic        data_i8, valid_i8, ready_i8;
    logic [7:0]  data_o8;
    logic        valid_o8, overflow_o8, frame_err_o8;

    logic        data_i32, valid_i32, ready_i32;
    logic [31:0] data_o32;
    logic        valid_o32, overflow_o32, frame_err_o32;

    int vectors     = 0;
    int miscompares = 0;

    int ovf_cnt8 = 0, ferr_cnt8 = 0, ovf_cnt32 = 0, ferr_cnt32 = 0;

    logic [7:0]  exp_q8[$];
    logic [31:0] exp_q32[$];

    shift_deserializer #(.TO(8), .LOG2TO(3)) dut8 (
        .clk(clk), .reset(reset), .data_i(data_i8), .valid_i(valid_i8),
        .ready_i(ready_i8), .data_o(data_o8), .valid_o(valid_o8),
        .overflow_o(overflow_o8), .frame_err_o(frame_err_o8)
    );

    shift_deserializer #(.TO(32), .LOG2TO(5)) dut32 (
        .clk(clk), .reset(reset), .data_i(data_i32), .valid_i(valid_i32),
        .ready_i(ready_i32), .data_o(data_o32), .valid_o(valid_o32),
        .overflow_o(overflow_o32), .frame_err_o(frame_err_o32)
    );

    always #5 clk = ~clk;

    // Count flag-high cycles away from the active edge
    always @(negedge clk) begin
        if (overflow_o8)   ovf_cnt8++;
        if (frame_err_o8)  ferr_cnt8++;
        if (overflow_o32)  ovf_cnt32++;
        if (frame_err_o32) ferr_cnt32++;
    end

    task automatic cyc8(input logic v, input logic d);
        valid_i8 = v; data_i8 = d;
        @(posedge clk); #1;
    endtask

    task automatic cyc32(input logic v, input logic d);
        valid_i32 = v; data_i32 = d;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid_i8 = 0; data_i8 = 0; ready_i8 = 0;
        valid_i32 = 0; data_i32 = 0; ready_i32 = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if ({valid_o8, overflow_o8, frame_err_o8} !== 3'b000) begin miscompares++; $display("FAIL reset_flags8 got %b want 000", {valid_o8, overflow_o8, frame_err_o8}); end
        vectors++; if (data_o8 !== 8'h00) begin miscompares++; $display("FAIL reset_data8 got %h want 00", data_o8); end
        vectors++; if ({valid_o32, overflow_o32, frame_err_o32} !== 3'b000) begin miscompares++; $display("FAIL reset_flags32 got %b want 000", {valid_o32, overflow_o32, frame_err_o32}); end
        vectors++; if (data_o32 !== 32'h0) begin miscompares++; $display("FAIL reset_data32 got %h want 0", data_o32); end
        reset = 1'b0;
        cyc8(0, 0);
        $display("test_reset done");
    endtask

    task automatic test_basic;
        logic [7:0] w = 8'hA5;
        logic [7:0] e;
        int f0 = ferr_cnt8, o0 = ovf_cnt8;
        ready_i8 = 1;
        exp_q8.push_back(w);
        for (int i = 7; i >= 1; i--) cyc8(1, w[i]);
        vectors++; if (valid_o8 !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b want 0", valid_o8); end
        cyc8(1, w[0]);
        vectors++; if (valid_o8 !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", valid_o8); end
        e = exp_q8.pop_front();
        vectors++; if (data_o8 !== e) begin miscompares++; $display("FAIL basic_data got %h want %h", data_o8, e); end
        cyc8(1, 1);   // trailing bit, word consumed at this edge
        vectors++; if (valid_o8 !== 1'b0) begin miscompares++; $display("FAIL basic_drop_valid got %b want 0", valid_o8); end
        cyc8(0, 0);
        cyc8(0, 0);
        vectors++; if ((ferr_cnt8 - f0) != 0 || (ovf_cnt8 - o0) != 0) begin miscompares++; $display("FAIL basic_flags got ferr=%0d ovf=%0d want 0/0", ferr_cnt8 - f0, ovf_cnt8 - o0); end
        $display("test_basic word %h", w);
    endtask

    task automatic test_frame_err;
        logic [7:0] w = 8'h3C;
        logic [7:0] e;
        int f0 = ferr_cnt8;
        ready_i8 = 1;
        cyc8(1, 1); cyc8(1, 1); cyc8(1, 0); cyc8(1, 1); cyc8(1, 1);
        cyc8(0, 0);
        vectors++; if (frame_err_o8 !== 1'b1) begin miscompares++; $display("FAIL ferr_pulse got %b want 1", frame_err_o8); end
        vectors++; if (valid_o8 !== 1'b0) begin miscompares++; $display("FAIL ferr_valid got %b want 0", valid_o8); end
        cyc8(0, 0);
        vectors++; if ((ferr_cnt8 - f0) != 1) begin miscompares++; $display("FAIL ferr_count got %0d want 1", ferr_cnt8 - f0); end
        exp_q8.push_back(w);
        for (int i = 7; i >= 0; i--) cyc8(1, w[i]);
        e = exp_q8.pop_front();
        vectors++; if (valid_o8 !== 1'b1 || data_o8 !== e) begin miscompares++; $display("FAIL ferr_next got v=%b %h want v=1 %h", valid_o8, data_o8, e); end
        cyc8(0, 0);
        cyc8(0, 0);
        vectors++; if ((ferr_cnt8 - f0) != 1) begin miscompares++; $display("FAIL ferr_after got %0d want 1", ferr_cnt8 - f0); end
        $display("test_frame_err recovered word %h", w);
    endtask

    task automatic test_overflow;
        logic [7:0] w1 = 8'h11, w2 = 8'h22;
        logic [7:0] e;
        int o0 = ovf_cnt8;
        ready_i8 = 0;
        exp_q8.push_back(w1);
        for (int i = 7; i >= 0; i--) cyc8(1, w1[i]);
        cyc8(0, 0);
        for (int i = 7; i >= 0; i--) cyc8(1, w2[i]);   // dropped: slot full
        vectors++; if (overflow_o8 !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse got %b want 1", overflow_o8); end
        vectors++; if (valid_o8 !== 1'b1 || data_o8 !== w1) begin miscompares++; $display("FAIL ovf_hold got v=%b %h want v=1 %h", valid_o8, data_o8, w1); end
        cyc8(0, 0);
        vectors++; if (overflow_o8 !== 1'b0 || data_o8 !== w1) begin miscompares++; $display("FAIL ovf_end got ovf=%b %h want ovf=0 %h", overflow_o8, data_o8, w1); end
        ready_i8 = 1;
        e = exp_q8.pop_front();
        vectors++; if (data_o8 !== e) begin miscompares++; $display("FAIL ovf_xfer got %h want %h", data_o8, e); end
        cyc8(0, 0);
        vectors++; if (valid_o8 !== 1'b0) begin miscompares++; $display("FAIL ovf_valid_drop got %b want 0", valid_o8); end
        cyc8(0, 0);
        vectors++; if ((ovf_cnt8 - o0) != 1) begin miscompares++; $display("FAIL ovf_count got %0d want 1", ovf_cnt8 - o0); end
        $display("test_overflow held %h dropped %h", w1, w2);
    endtask

    task automatic test_same_edge;
        logic [7:0] w1 = 8'h11, w2 = 8'h22;
        logic [7:0] e;
        int o0 = ovf_cnt8;
        ready_i8 = 0;
        exp_q8.push_back(w1);
        for (int i = 7; i >= 0; i--) cyc8(1, w1[i]);
        cyc8(0, 0);
        exp_q8.push_back(w2);
        for (int i = 7; i >= 1; i--) begin
            cyc8(1, w2[i]);
            vectors++; if (valid_o8 !== 1'b1) begin miscompares++; $display("FAIL same_hold_valid bit %0d got %b want 1", i, valid_o8); end
        end
        ready_i8 = 1;
        e = exp_q8.pop_front();
        vectors++; if (data_o8 !== e) begin miscompares++; $display("FAIL same_first got %h want %h", data_o8, e); end
        cyc8(1, w2[0]);
        e = exp_q8.pop_front();
        vectors++; if (valid_o8 !== 1'b1 || data_o8 !== e) begin miscompares++; $display("FAIL same_second got v=%b %h want v=1 %h", valid_o8, data_o8, e); end
        cyc8(0, 0);
        vectors++; if (valid_o8 !== 1'b0) begin miscompares++; $display("FAIL same_drain got %b want 0", valid_o8); end
        cyc8(0, 0);
        vectors++; if ((ovf_cnt8 - o0) != 0) begin miscompares++; $display("FAIL same_ovf got %0d want 0", ovf_cnt8 - o0); end
        $display("test_same_edge words %h %h", w1, w2);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] w0 = 8'h5A, w = 8'hF0;
        logic [7:0] e;
        int o0, f0;
        ready_i8 = 0;
        exp_q8.push_back(w0);
        for (int i = 7; i >= 0; i--) cyc8(1, w0[i]);
        cyc8(0, 0);
        cyc8(1, 1); cyc8(1, 0); cyc8(1, 1); cyc8(1, 1);
        o0 = ovf_cnt8; f0 = ferr_cnt8;
        #2 reset = 1'b1;
        #1;
        vectors++; if ({valid_o8, overflow_o8, frame_err_o8} !== 3'b000 || data_o8 !== 8'h00) begin miscompares++; $display("FAIL rst_async got v/o/f=%b %h want 000 00", {valid_o8, overflow_o8, frame_err_o8}, data_o8); end
        exp_q8.delete();
        valid_i8 = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc8(0, 0);
        vectors++; if ((ovf_cnt8 - o0) != 0 || (ferr_cnt8 - f0) != 0) begin miscompares++; $display("FAIL rst_flags got ovf=%0d ferr=%0d want 0/0", ovf_cnt8 - o0, ferr_cnt8 - f0); end
        ready_i8 = 1;
        exp_q8.push_back(w);
        for (int i = 7; i >= 0; i--) cyc8(1, w[i]);
        e = exp_q8.pop_front();
        vectors++; if (valid_o8 !== 1'b1 || data_o8 !== e) begin miscompares++; $display("FAIL rst_next got v=%b %h want v=1 %h", valid_o8, data_o8, e); end
        cyc8(0, 0);
        $display("test_reset_midframe word %h", w);
    endtask

    task automatic test_back_to_back;
        logic [7:0] words[2] = '{8'h81, 8'h7E};
        logic [7:0] e;
        logic [7:0] w;
        ready_i8 = 1;
        for (int k = 0; k < 2; k++) begin
            w = words[k];
            exp_q8.push_back(w);
            for (int i = 7; i >= 0; i--) cyc8(1, w[i]);
            e = exp_q8.pop_front();
            vectors++; if (valid_o8 !== 1'b1 || data_o8 !== e) begin miscompares++; $display("FAIL b2b_%0d got v=%b %h want v=1 %h", k, valid_o8, data_o8, e); end
            cyc8(0, 0);
            $display("test_back_to_back word %h", w);
        end
    endtask

    task automatic test_wide;
        logic [31:0] w = 32'hDEADBEEF;
        logic [31:0] e;
        int f0 = ferr_cnt32, o0 = ovf_cnt32;
        ready_i32 = 1;
        exp_q32.push_back(w);
        for (int i = 31; i >= 0; i--) cyc32(1, w[i]);
        e = exp_q32.pop_front();
        vectors++; if (valid_o32 !== 1'b1 || data_o32 !== e) begin miscompares++; $display("FAIL wide_word got v=%b %h want v=1 %h", valid_o32, data_o32, e); end
        cyc32(1, 1);   // 33rd bit
        vectors++; if (valid_o32 !== 1'b0 || data_o32 !== w) begin miscompares++; $display("FAIL wide_trail got v=%b %h want v=0 %h", valid_o32, data_o32, w); end
        cyc32(0, 0);
        cyc32(0, 0);
        vectors++; if ((ferr_cnt32 - f0) != 0 || (ovf_cnt32 - o0) != 0) begin miscompares++; $display("FAIL wide_flags got ferr=%0d ovf=%0d want 0/0", ferr_cnt32 - f0, ovf_cnt32 - o0); end
        $display("test_wide word %h", w);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_overflow();
        test_same_edge();
        test_reset_midframe();
        test_back_to_back();
        test_wide();
        vectors++; if (exp_q8.size() != 0 || exp_q32.size() != 0) begin miscompares++; $display("FAIL scoreboard_left got %0d/%0d want 0/0", exp_q8.size(), exp_q32.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
